ddr_event_writer: RTL and testbench

- Upstream feeder for the DDR2 ram_controller local interface, running in the phy_clk domain.
- Accepts a stream of 64-bit event words on a valid/ready port and buffers them in a small FIFO.
- Issues Avalon-style local write bursts of BURST_LEN beats into a circular region of DDR2 memory.
- Supports flush of partial bursts and reports the write pointer, a word count and a wrap flag to downstream readout logic.

---
 rtl/ddr_pkg.sv | 9 +
 rtl/sync_fifo_fwft.sv | 38 +++
 rtl/ddr_event_writer.sv | 147 ++++++++++++++
 tb/tb_ddr_event_writer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared defaults and types for the DDR2 local-interface event path.
package ddr_pkg;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 24;
   localparam int unsigned SIZE_W = 3;
   localparam logic [DATA_W/8-1:0] BE_ALL = '1;

   typedef enum logic [1:0] {ST_INIT, ST_WAIT, ST_BURST} state_e;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead FIFO: the oldest entry is always presented on head_c, with an occupancy count.
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_c,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (push) wr_idx <= wr_idx + AW'(1);
         if (pop)  rd_idx <= rd_idx + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage is not reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_idx] <= push_data;
   end

   assign head_c = mem[rd_idx];
endmodule

// File: rtl/ddr_event_writer.sv
// Buffers event words and writes them as bursts into a circular DDR2 region.
module ddr_event_writer
   import ddr_pkg::*;
#(
   parameter int unsigned        DATA_W     = ddr_pkg::DATA_W,
   parameter int unsigned        ADDR_W     = ddr_pkg::ADDR_W,
   parameter int unsigned        SIZE_W     = ddr_pkg::SIZE_W,
   parameter int unsigned        BURST_LEN  = 4,
   parameter int unsigned        FIFO_DEPTH = 16,
   parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
   parameter logic [ADDR_W-1:0]  END_ADDR   = '1
) (
   input  logic                phy_clk,
   input  logic                reset_phy_clk_n,
   input  logic                local_init_done,
   input  logic                enable,
   input  logic                flush,
   output logic                flush_done,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [ADDR_W-1:0]   local_address,
   output logic [SIZE_W-1:0]   local_size,
   output logic                local_burstbegin,
   output logic                local_write_req,
   output logic [DATA_W-1:0]   local_wdata,
   output logic [DATA_W/8-1:0] local_be,
   input  logic                local_ready,
   output logic [ADDR_W-1:0]   wr_ptr,
   output logic [31:0]         words_written,
   output logic                wrapped
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned PW = ADDR_W + 1;

   state_e             state, state_next;
   logic [CW-1:0]      count;
   logic               fifo_push, beat_ok;
   logic [SIZE_W-1:0]  beat_cnt, beat_cnt_next;
   logic [SIZE_W-1:0]  cand, burst_sz, size_next;
   logic [PW-1:0]      space;
   logic               end_hit;
   logic [ADDR_W-1:0]  addr_next, wr_ptr_next;
   logic [31:0]        words_next;
   logic               wrapped_next, flush_pending, pending_next;
   logic               flush_done_next, begin_next;

   assign local_be  = {(DATA_W/8){BE_ALL[0]}};
   assign fifo_push = in_valid & in_ready;
   assign beat_ok   = local_write_req & local_ready;

   sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (phy_clk),
      .rst_n     (reset_phy_clk_n),
      .push      (fifo_push),
      .push_data (in_data),
      .pop       (beat_ok),
      .head_c    (local_wdata),
      .count     (count)
   );

   // Burst size: limited by occupancy, nominal length and room left before END_ADDR.
   assign cand     = (count < CW'(BURST_LEN)) ? SIZE_W'(count) : SIZE_W'(BURST_LEN);
   assign space    = PW'(END_ADDR) - PW'(wr_ptr) + PW'(1);
   assign burst_sz = (space < PW'(cand)) ? SIZE_W'(space) : cand;
   assign end_hit  = (PW'(wr_ptr) + PW'(local_size)) == (PW'(END_ADDR) + PW'(1));

   always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
      if (!reset_phy_clk_n) begin
         state            <= ST_INIT;
         local_address    <= BASE_ADDR;
         local_size       <= '0;
         local_burstbegin <= 1'b0;
         beat_cnt         <= '0;
         wr_ptr           <= BASE_ADDR;
         words_written    <= '0;
         wrapped          <= 1'b0;
         flush_pending    <= 1'b0;
         flush_done       <= 1'b0;
      end else begin
         state            <= state_next;
         local_address    <= addr_next;
         local_size       <= size_next;
         local_burstbegin <= begin_next;
         beat_cnt         <= beat_cnt_next;
         wr_ptr           <= wr_ptr_next;
         words_written    <= words_next;
         wrapped          <= wrapped_next;
         flush_pending    <= pending_next;
         flush_done       <= flush_done_next;
      end
   end

   always_comb begin
      state_next      = state;
      addr_next       = local_address;
      size_next       = local_size;
      begin_next      = local_burstbegin;
      beat_cnt_next   = beat_cnt;
      wr_ptr_next     = wr_ptr;
      words_next      = words_written;
      wrapped_next    = wrapped;
      pending_next    = flush_pending | flush;
      flush_done_next = 1'b0;
      unique case (state)
         ST_INIT: begin
            if (local_init_done) state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (enable && ((count >= CW'(BURST_LEN)) || (flush_pending && (count != '0)))) begin
               addr_next     = wr_ptr;
               size_next     = burst_sz;
               beat_cnt_next = burst_sz;
               begin_next    = 1'b1;
               state_next    = ST_BURST;
            end else if (flush_pending && (count == '0)) begin
               pending_next    = 1'b0;
               flush_done_next = 1'b1;
            end
         end
         ST_BURST: begin
            if (beat_ok) begin
               begin_next    = 1'b0;
               beat_cnt_next = beat_cnt - SIZE_W'(1);
               words_next    = words_written + 32'd1;
               if (beat_cnt == SIZE_W'(1)) begin
                  state_next = ST_WAIT;
                  if (end_hit) begin
                     wr_ptr_next  = BASE_ADDR;
                     wrapped_next = 1'b1;
                  end else begin
                     wr_ptr_next = wr_ptr + ADDR_W'(local_size);
                  end
               end
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   always_comb begin
      local_write_req = 1'b0;
      in_ready        = 1'b0;
      if (state == ST_BURST) local_write_req = 1'b1;
      if (state != ST_INIT)  in_ready = (count < CW'(FIFO_DEPTH));
   end
endmodule

// File: tb/tb_ddr_event_writer.sv
// Scoreboard bench for ddr_event_writer on a small ring (BASE=0, END=9).
module tb_ddr_event_writer;
   localparam int BASE_A = 0;
   localparam int END_A  = 9;

   typedef struct packed {
      logic [23:0] addr;
      logic [2:0]  size;
      logic        bb;
      logic [63:0] data;
   } beat_t;

   logic        phy_clk = 1'b0;
   logic        reset_phy_clk_n = 1'b1;
   logic        local_init_done = 1'b0;
   logic        enable = 1'b0;
   logic        flush = 1'b0;
   logic        flush_done;
   logic [63:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] local_address;
   logic [2:0]  local_size;
   logic        local_burstbegin;
   logic        local_write_req;
   logic [63:0] local_wdata;
   logic [7:0]  local_be;
   logic        local_ready = 1'b1;
   logic [23:0] wr_ptr;
   logic [31:0] words_written;
   logic        wrapped;

   int tests = 0;
   int fails = 0;
   int fd_cnt = 0;
   int stall_bad = 0;
   bit stall_armed = 1'b0;
   beat_t stall_snap;

   beat_t       obs_q[$];
   beat_t       exp_q[$];
   logic [63:0] pend_q[$];
   int          m_ptr = BASE_A;
   int          m_words = 0;
   bit          m_wrapped = 1'b0;

   ddr_event_writer #(.END_ADDR(24'(END_A)), .BASE_ADDR(24'(BASE_A))) dut (
      .phy_clk          (phy_clk),
      .reset_phy_clk_n  (reset_phy_clk_n),
      .local_init_done  (local_init_done),
      .enable           (enable),
      .flush            (flush),
      .flush_done       (flush_done),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .local_address    (local_address),
      .local_size       (local_size),
      .local_burstbegin (local_burstbegin),
      .local_write_req  (local_write_req),
      .local_wdata      (local_wdata),
      .local_be         (local_be),
      .local_ready      (local_ready),
      .wr_ptr           (wr_ptr),
      .words_written    (words_written),
      .wrapped          (wrapped)
   );

   always #5 phy_clk = ~phy_clk;

   // Observe accepted beats, stall stability and flush_done pulses mid-cycle.
   always @(negedge phy_clk) begin
      beat_t cur;
      cur = '{addr: local_address, size: local_size, bb: local_burstbegin, data: local_wdata};
      if (!reset_phy_clk_n) begin
         stall_armed = 1'b0;
      end else begin
         if (local_write_req && local_ready) obs_q.push_back(cur);
         if (stall_armed && local_write_req && (cur !== stall_snap)) stall_bad++;
         stall_armed = local_write_req && !local_ready;
         stall_snap  = cur;
         if (flush_done) fd_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   function automatic string beat_str(input beat_t b);
      return $sformatf("addr=%0h size=%0d bb=%0b data=%0h", b.addr, b.size, b.bb, b.data);
   endfunction

   task automatic tick();
      @(posedge phy_clk);
      #1;
   endtask

   task automatic push_word(input logic [63:0] d);
      int guard = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      tick();
      in_valid = 1'b0;
      pend_q.push_back(d);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // Expected bursts for the words still queued, given the ring position.
   task automatic model_bursts(input bit fl);
      while (pend_q.size() >= 4 || (fl && pend_q.size() > 0)) begin
         int sz;
         sz = (pend_q.size() < 4) ? pend_q.size() : 4;
         if (END_A - m_ptr + 1 < sz) sz = END_A - m_ptr + 1;
         for (int b = 0; b < sz; b++) begin
            beat_t e;
            e.addr = 24'(m_ptr);
            e.size = 3'(sz);
            e.bb   = (b == 0);
            e.data = pend_q.pop_front();
            exp_q.push_back(e);
            m_words++;
         end
         m_ptr += sz;
         if (m_ptr > END_A) begin
            m_ptr     = BASE_A;
            m_wrapped = 1'b1;
         end
      end
   endtask

   task automatic wait_obs(input int n, input bit toggle);
      int guard = 0;
      while (obs_q.size() < n && guard < 400) begin
         tick();
         guard++;
         if (toggle) local_ready = ~local_ready;
      end
      repeat (4) tick();
      local_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset_phy_clk_n = 1'b0;
      #2;
      tests++;
      if (local_write_req !== 1'b0 || local_burstbegin !== 1'b0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: req=%b bb=%b in_ready=%b, want 0 0 0", local_write_req, local_burstbegin, in_ready);
      end
      tests++;
      if (local_size !== 3'd0 || local_address !== 24'(BASE_A) || wr_ptr !== 24'(BASE_A)) begin
         fails++;
         $display("FAIL reset_addr: size=%0d addr=%0h wr_ptr=%0h, want 0 %0h %0h", local_size, local_address, wr_ptr, BASE_A, BASE_A);
      end
      tests++;
      if (words_written !== 32'd0 || wrapped !== 1'b0 || flush_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_status: words=%0d wrapped=%b flush_done=%b, want 0 0 0", words_written, wrapped, flush_done);
      end
      tests++;
      if (local_be !== 8'hFF) begin
         fails++;
         $display("FAIL byte_enable: got %h want ff", local_be);
      end
      @(posedge phy_clk);
      #1 reset_phy_clk_n = 1'b1;
   endtask

   task automatic test_init_hold();
      int bad_ready = 0;
      int bad_req = 0;
      enable   = 1'b1;
      in_valid = 1'b1;
      pulse_flush();
      for (int i = 0; i < 8; i++) begin
         in_data = 64'(i + 100);
         if (in_ready !== 1'b0) bad_ready++;
         if (local_write_req !== 1'b0) bad_req++;
         tick();
      end
      in_valid = 1'b0;
      enable   = 1'b0;
      tests++;
      if (bad_ready != 0 || bad_req != 0) begin
         fails++;
         $display("FAIL init_hold: in_ready high %0d cycles, req high %0d cycles, want 0 0", bad_ready, bad_req);
      end
      local_init_done = 1'b1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL init_exit_edge: in_ready=%b want 0", in_ready);
      end
      tick();
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL init_ready: in_ready=%b want 1", in_ready);
      end
      repeat (5) tick();
      tests++;
      if (fd_cnt !== 1 || obs_q.size() !== 0 || words_written !== 32'd0) begin
         fails++;
         $display("FAIL init_flush: flush_done pulses=%0d beats=%0d words=%0d, want 1 0 0", fd_cnt, obs_q.size(), words_written);
      end
      obs_q.delete();
   endtask

   task automatic test_full_bursts();
      beat_t e, o;
      for (int i = 1; i <= 8; i++) push_word(64'(i));
      enable = 1'b1;
      model_bursts(1'b0);
      wait_obs(8, 1'b0);
      enable = 1'b0;
      tests++;
      if (obs_q.size() !== exp_q.size()) begin
         fails++;
         $display("FAIL full_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         tests++;
         if (o !== e) begin
            fails++;
            $display("FAIL full_beat: got %s want %s", beat_str(o), beat_str(e));
         end
      end
      exp_q.delete();
      obs_q.delete();
      tests++;
      if (wr_ptr !== 24'(m_ptr) || words_written !== 32'(m_words) || wrapped !== m_wrapped) begin
         fails++;
         $display("FAIL full_status: wr_ptr=%0d words=%0d wrapped=%b want %0d %0d %b", wr_ptr, words_written, wrapped, m_ptr, m_words, m_wrapped);
      end
   endtask

   task automatic test_wrap();
      beat_t e, o;
      int fd0;
      for (int i = 0; i < 4; i++) push_word(64'h11 + 64'(i));
      enable = 1'b1;
      model_bursts(1'b0);
      wait_obs(2, 1'b0);
      tests++;
      if (wrapped !== 1'b1 || wr_ptr !== 24'(m_ptr) || obs_q.size() !== exp_q.size()) begin
         fails++;
         $display("FAIL wrap_first: wrapped=%b wr_ptr=%0d beats=%0d want 1 %0d %0d", wrapped, wr_ptr, obs_q.size(), m_ptr, exp_q.size());
      end
      fd0 = fd_cnt;
      pulse_flush();
      model_bursts(1'b1);
      wait_obs(4, 1'b0);
      enable = 1'b0;
      tests++;
      if (obs_q.size() !== exp_q.size() || fd_cnt - fd0 !== 1) begin
         fails++;
         $display("FAIL wrap_flush: beats=%0d flush_done pulses=%0d want %0d 1", obs_q.size(), fd_cnt - fd0, exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         tests++;
         if (o !== e) begin
            fails++;
            $display("FAIL wrap_beat: got %s want %s", beat_str(o), beat_str(e));
         end
      end
      exp_q.delete();
      obs_q.delete();
      tests++;
      if (wr_ptr !== 24'(m_ptr) || words_written !== 32'(m_words)) begin
         fails++;
         $display("FAIL wrap_status: wr_ptr=%0d words=%0d want %0d %0d", wr_ptr, words_written, m_ptr, m_words);
      end
   endtask

   task automatic test_backpressure();
      beat_t e, o;
      stall_bad = 0;
      for (int i = 0; i < 8; i++) push_word(64'h21 + 64'(i));
      enable = 1'b1;
      model_bursts(1'b0);
      wait_obs(8, 1'b1);
      enable = 1'b0;
      tests++;
      if (obs_q.size() !== exp_q.size()) begin
         fails++;
         $display("FAIL bp_count: got %0d pops want %0d", obs_q.size(), exp_q.size());
      end
      tests++;
      if (stall_bad !== 0) begin
         fails++;
         $display("FAIL bp_stall: outputs changed during %0d stalled cycles, want 0", stall_bad);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         tests++;
         if (o !== e) begin
            fails++;
            $display("FAIL bp_beat: got %s want %s", beat_str(o), beat_str(e));
         end
      end
      exp_q.delete();
      obs_q.delete();
      tests++;
      if (wr_ptr !== 24'(m_ptr) || words_written !== 32'(m_words) || wrapped !== m_wrapped) begin
         fails++;
         $display("FAIL bp_status: wr_ptr=%0d words=%0d wrapped=%b want %0d %0d %b", wr_ptr, words_written, wrapped, m_ptr, m_words, m_wrapped);
      end
   endtask

   task automatic test_flush_partial();
      beat_t e, o;
      int fd0;
      for (int i = 0; i < 3; i++) push_word(64'h31 + 64'(i));
      enable = 1'b1;
      repeat (6) tick();
      tests++;
      if (obs_q.size() !== 0 || local_write_req !== 1'b0) begin
         fails++;
         $display("FAIL partial_hold: beats=%0d req=%b want 0 0", obs_q.size(), local_write_req);
      end
      fd0 = fd_cnt;
      pulse_flush();
      model_bursts(1'b1);
      wait_obs(3, 1'b0);
      enable = 1'b0;
      tests++;
      if (obs_q.size() !== exp_q.size() || fd_cnt - fd0 !== 1) begin
         fails++;
         $display("FAIL partial_flush: beats=%0d flush_done pulses=%0d want %0d 1", obs_q.size(), fd_cnt - fd0, exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         tests++;
         if (o !== e) begin
            fails++;
            $display("FAIL partial_beat: got %s want %s", beat_str(o), beat_str(e));
         end
      end
      exp_q.delete();
      obs_q.delete();
      tests++;
      if (wr_ptr !== 24'(m_ptr) || words_written !== 32'(m_words)) begin
         fails++;
         $display("FAIL partial_status: wr_ptr=%0d words=%0d want %0d %0d", wr_ptr, words_written, m_ptr, m_words);
      end
   endtask

   task automatic test_reset_mid_burst();
      int guard = 0;
      int fd0;
      for (int i = 0; i < 4; i++) push_word(64'h41 + 64'(i));
      enable = 1'b1;
      while (obs_q.size() < 2 && guard < 100) begin
         tick();
         guard++;
      end
      tests++;
      if (local_write_req !== 1'b1) begin
         fails++;
         $display("FAIL rst_pre: req=%b want 1 before reset", local_write_req);
      end
      reset_phy_clk_n = 1'b0;
      #1;
      tests++;
      if (local_write_req !== 1'b0 || local_burstbegin !== 1'b0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL rst_async: req=%b bb=%b in_ready=%b want 0 0 0", local_write_req, local_burstbegin, in_ready);
      end
      tests++;
      if (wr_ptr !== 24'(BASE_A) || words_written !== 32'd0 || wrapped !== 1'b0 || local_size !== 3'd0) begin
         fails++;
         $display("FAIL rst_status: wr_ptr=%0d words=%0d wrapped=%b size=%0d want %0d 0 0 0", wr_ptr, words_written, wrapped, local_size, BASE_A);
      end
      obs_q.delete();
      exp_q.delete();
      pend_q.delete();
      m_ptr = BASE_A;
      m_words = 0;
      m_wrapped = 1'b0;
      tick();
      reset_phy_clk_n = 1'b1;
      tick();
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL rst_ready: in_ready=%b want 1", in_ready);
      end
      repeat (6) tick();
      fd0 = fd_cnt;
      pulse_flush();
      repeat (6) tick();
      enable = 1'b0;
      tests++;
      if (obs_q.size() !== 0 || fd_cnt - fd0 !== 1 || words_written !== 32'd0) begin
         fails++;
         $display("FAIL rst_empty: beats=%0d flush_done pulses=%0d words=%0d want 0 1 0", obs_q.size(), fd_cnt - fd0, words_written);
      end
   endtask

   initial begin
      test_reset();
      test_init_hold();
      test_full_bursts();
      test_wrap();
      test_backpressure();
      test_flush_partial();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
